// File: rtl/kamus_pkg.sv
// Shared encodings for the kamus core and its tightly coupled memory.
// Size codes mirror funct3[1:0] of the load/store instructions.
package kamus_pkg;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {S_CLEAR, S_READY} tcm_state_e;

  // Size code 2'b11 has no legal meaning and is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/kamus_tcm_bank.sv
// Two-port read-first word RAM: read-only fetch port, byte-enabled data port.
// One-cycle registered reads on both ports; no backpressure.
module kamus_tcm_bank #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [31:0]   i_rdata_o,
  input  logic [AW-1:0] d_addr_i,
  input  logic [3:0]    d_be_i,
  input  logic [31:0]   d_wdata_i,
  output logic [31:0]   d_rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  // Reads and writes share one process so both reads see the pre-write word.
  always_ff @(posedge clk_i) begin
    i_rdata_q <= mem_q[i_addr_i];
    d_rdata_q <= mem_q[d_addr_i];
    for (int b = 0; b < 4; b++) begin
      if (d_be_i[b]) mem_q[d_addr_i][8*b +: 8] <= d_wdata_i[8*b +: 8];
    end
  end

  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;

endmodule

// File: rtl/kamus_tcm.sv
// Tightly coupled memory serving kamus_core fetch and load/store ports after a post-reset clear.
// Responses return RD_LATENCY cycles after each request, in order; requests are never stalled.
module kamus_tcm
  import kamus_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        ready_o,
  input  logic [31:0] l1i_instr_addr_i,
  output logic [31:0] l1i_instr_data_o,
  input  logic        l1d_req_i,
  input  logic        l1d_wr_en_i,
  input  logic [1:0]  l1d_size_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [31:0] l1d_wr_data_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        l1d_rd_valid_o,
  output logic        l1d_misalign_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  tcm_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clear_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (CLEAR_ON_RESET == 0 || cnt_q == AW'(DEPTH_WORDS - 1)) state_d = S_READY;
        else cnt_d = cnt_q + AW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_READY);
    clear_we = (state_q == S_CLEAR) && (CLEAR_ON_RESET != 0);
  end

  logic [1:0]  lane;
  logic        accept, mis, st, ld;
  logic [AW-1:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, d_rdata, i_rdata;

  assign lane   = l1d_addr_i[1:0];
  assign accept = ready_o & l1d_req_i;
  assign mis    = accept & is_misaligned(l1d_size_i, lane);
  assign st     = accept & l1d_wr_en_i & ~mis;
  assign ld     = accept & ~l1d_wr_en_i & ~mis;

  // The clear sequence borrows the data port; requests are not accepted meanwhile.
  assign d_addr  = clear_we ? cnt_q : l1d_addr_i[AW+1:2];
  assign d_be    = clear_we ? 4'hF : (st ? byte_en(l1d_size_i, lane) : 4'h0);
  assign d_wdata = clear_we ? 32'h0 : (l1d_wr_data_i << {lane, 3'b000});

  kamus_tcm_bank #(.AW(AW)) u_bank (
    .clk_i     (clk_i),
    .i_addr_i  (l1i_instr_addr_i[AW+1:2]),
    .i_rdata_o (i_rdata),
    .d_addr_i  (d_addr),
    .d_be_i    (d_be),
    .d_wdata_i (d_wdata),
    .d_rdata_o (d_rdata)
  );

  logic        vld1_q, ld1_q, mis1_q, ifv1_q;
  logic [31:0] rdat1, inst1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld1_q <= 1'b0;
      ld1_q  <= 1'b0;
      mis1_q <= 1'b0;
      ifv1_q <= 1'b0;
    end else begin
      vld1_q <= accept;
      ld1_q  <= ld;
      mis1_q <= mis;
      ifv1_q <= ready_o;
    end
  end

  assign rdat1 = ld1_q ? d_rdata : 32'h0;
  assign inst1 = ifv1_q ? i_rdata : INSTR_NOP;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign l1d_rd_valid_o   = vld1_q;
      assign l1d_misalign_o   = mis1_q;
      assign l1d_rd_data_o    = rdat1;
      assign l1i_instr_data_o = inst1;
    end else begin : g_lat2
      logic        vld2_q, mis2_q;
      logic [31:0] rdat2_q, inst2_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld2_q  <= 1'b0;
          mis2_q  <= 1'b0;
          rdat2_q <= 32'h0;
          inst2_q <= INSTR_NOP;
        end else begin
          vld2_q  <= vld1_q;
          mis2_q  <= mis1_q;
          rdat2_q <= rdat1;
          inst2_q <= inst1;
        end
      end
      assign l1d_rd_valid_o   = vld2_q;
      assign l1d_misalign_o   = mis2_q;
      assign l1d_rd_data_o    = rdat2_q;
      assign l1i_instr_data_o = inst2_q;
    end
  endgenerate

  // High address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^{l1i_instr_addr_i[31:AW+2], l1i_instr_addr_i[1:0], l1d_addr_i[31:AW+2]};

endmodule

// File: tb/tb_kamus_tcm.sv
// Directed bench for kamus_tcm: one instance per legal read latency, driven in lockstep.
module tb_kamus_tcm;
  import kamus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr_addr = '0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = SZ_WORD;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic rdy1, vld1, mis1, rdy2, vld2, mis2;
  logic [31:0] idat1, rdat1, idat2, rdat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kamus_tcm #(.DEPTH_WORDS(16), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy1),
    .l1i_instr_addr_i(instr_addr), .l1i_instr_data_o(idat1),
    .l1d_req_i(req), .l1d_wr_en_i(wr), .l1d_size_i(size), .l1d_addr_i(addr),
    .l1d_wr_data_i(wdata), .l1d_rd_data_o(rdat1), .l1d_rd_valid_o(vld1), .l1d_misalign_o(mis1)
  );

  kamus_tcm #(.DEPTH_WORDS(16), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy2),
    .l1i_instr_addr_i(instr_addr), .l1i_instr_data_o(idat2),
    .l1d_req_i(req), .l1d_wr_en_i(wr), .l1d_size_i(size), .l1d_addr_i(addr),
    .l1d_wr_data_i(wdata), .l1d_rd_data_o(rdat2), .l1d_rd_valid_o(vld2), .l1d_misalign_o(mis2)
  );

  // One request; r1/r2 = {valid, misalign, data} at latency 1 and 2 of each instance.
  task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output logic [33:0] r1, output logic [33:0] r2,
                        output logic early2, output logic late1);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    @(posedge clk); #1;
    r1 = {vld1, mis1, rdat1};
    early2 = vld2;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    r2 = {vld2, mis2, rdat2};
    late1 = vld1;
  endtask

  // Counts cycles from reset release until ready; also checks the idle outputs on the way.
  task automatic wait_ready(input string tag, output int n);
    logic got;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy2) got = 1'b1;
      else begin
        checks++;
        if ({vld1, vld2, idat1, idat2, rdy1} !== {2'b00, INSTR_NOP, INSTR_NOP, 1'b0}) begin
          errors++;
          $display("FAIL %s_clear_idle: got vld=%b%b idat=%h/%h rdy1=%b, exp vld=00 idat=%h rdy1=0",
                   tag, vld1, vld2, idat1, idat2, rdy1, INSTR_NOP);
        end
      end
    end
  endtask

  task automatic test_reset;
    int n;
    logic [33:0] r1, r2;
    logic e2, l1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy1, vld1, mis1, rdat1, idat1, rdy2, vld2, mis2, rdat2, idat2} !==
        {3'b000, 32'h0, INSTR_NOP, 3'b000, 32'h0, INSTR_NOP}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b%b vld=%b%b mis=%b%b rdat=%h/%h idat=%h/%h, exp zeros and idat=%h",
               rdy1, rdy2, vld1, vld2, mis1, mis2, rdat1, rdat2, idat1, idat2, INSTR_NOP);
    end
    // A store held during the clear must be ignored.
    @(negedge clk);
    rst = 1'b0; req = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h0; wdata = 32'hDEAD_BEEF;
    wait_ready("reset", n);
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (n !== 16 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL ready_delay: got %0d cycles rdy1=%b, exp 16 cycles rdy1=1", n, rdy1);
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b0, SZ_WORD, 32'(i * 4), 32'h0, r1, r2, e2, l1);
      checks++;
      if ({r1, r2, e2, l1} !== {2'b10, 32'h0, 2'b10, 32'h0, 2'b00}) begin
        errors++;
        $display("FAIL cleared_word_%0d: got r1=%h r2=%h early2=%b late1=%b, exp r1=200000000 r2=200000000 early/late 0",
                 i, r1, r2, e2, l1);
      end
    end
  endtask

  task automatic test_store_load;
    logic [33:0] r1, r2;
    logic e2, l1;
    access(1'b1, SZ_WORD, 32'h4, 32'h0111_111F, r1, r2, e2, l1);
    checks++;
    if ({r1, r2, e2, l1} !== {2'b10, 32'h0, 2'b10, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL sw_ack: got r1=%h r2=%h early2=%b late1=%b, exp acks with zero data", r1, r2, e2, l1);
    end
    access(1'b0, SZ_WORD, 32'h4, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2, e2, l1} !== {2'b10, 32'h0111_111F, 2'b10, 32'h0111_111F, 2'b00}) begin
      errors++;
      $display("FAIL lw_after_sw: got r1=%h r2=%h early2=%b late1=%b, exp data 0111111f", r1, r2, e2, l1);
    end
  endtask

  task automatic test_subword;
    logic [33:0] r1, r2;
    logic e2, l1;
    access(1'b1, SZ_BYTE, 32'h5, 32'h0000_00AB, r1, r2, e2, l1);
    access(1'b1, SZ_HALF, 32'h6, 32'h0000_BEEF, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'h0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL sh_ack: got r1=%h r2=%h, exp acks with zero data", r1, r2);
    end
    access(1'b0, SZ_WORD, 32'h4, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'hBEEF_AB1F, 2'b10, 32'hBEEF_AB1F}) begin
      errors++;
      $display("FAIL sb_sh_merge: got r1=%h r2=%h, exp data beefab1f", r1, r2);
    end
    // Byte loads still return the whole unshifted word.
    access(1'b0, SZ_BYTE, 32'h5, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'hBEEF_AB1F, 2'b10, 32'hBEEF_AB1F}) begin
      errors++;
      $display("FAIL lb_raw_word: got r1=%h r2=%h, exp data beefab1f", r1, r2);
    end
  endtask

  task automatic test_misalign;
    logic [33:0] r1, r2;
    logic e2, l1;
    logic [1:0]  msz [4];
    logic [31:0] mad [4];
    logic        mwr [4];
    msz = '{SZ_WORD, SZ_HALF, 2'b11, SZ_WORD};
    mad = '{32'h2, 32'h5, 32'h0, 32'h1};
    mwr = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      access(mwr[i], msz[i], mad[i], 32'hFFFF_FFFF, r1, r2, e2, l1);
      checks++;
      if ({r1, r2, e2, l1} !== {2'b11, 32'h0, 2'b11, 32'h0, 2'b00}) begin
        errors++;
        $display("FAIL misalign_%0d: got r1=%h r2=%h early2=%b late1=%b, exp valid+misalign with zero data",
                 i, r1, r2, e2, l1);
      end
    end
    access(1'b0, SZ_WORD, 32'h0, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'h0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL misalign_nowrite0: got r1=%h r2=%h, exp data 00000000", r1, r2);
    end
    access(1'b0, SZ_WORD, 32'h4, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'hBEEF_AB1F, 2'b10, 32'hBEEF_AB1F}) begin
      errors++;
      $display("FAIL misalign_nowrite4: got r1=%h r2=%h, exp data beefab1f", r1, r2);
    end
    // Aligned upper half and top byte, with junk in the unused store bits.
    access(1'b1, SZ_HALF, 32'h2, 32'hFFFF_1234, r1, r2, e2, l1);
    access(1'b1, SZ_BYTE, 32'h3, 32'hFFFF_FF77, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'h0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL sb3_ack: got r1=%h r2=%h, exp acks with zero data", r1, r2);
    end
    access(1'b0, SZ_WORD, 32'h0, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'h7734_0000, 2'b10, 32'h7734_0000}) begin
      errors++;
      $display("FAIL upper_lanes: got r1=%h r2=%h, exp data 77340000", r1, r2);
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] a1 [3];
    logic [33:0] a2 [3];
    logic [33:0] exp_r [3];
    logic        tail1;
    logic        wv [3];
    logic [31:0] av [3];
    wv = '{1'b1, 1'b0, 1'b0};
    av = '{32'h8, 32'h8, 32'h4};
    exp_r = '{{2'b10, 32'h0}, {2'b10, 32'hCAFE_F00D}, {2'b10, 32'hBEEF_AB1F}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        req = 1'b1; wr = wv[i]; size = SZ_WORD; addr = av[i]; wdata = 32'hCAFE_F00D;
      end else req = 1'b0;
      @(posedge clk); #1;
      if (i < 3) a1[i] = {vld1, mis1, rdat1};
      else tail1 = vld1;
      if (i > 0) a2[i-1] = {vld2, mis2, rdat2};
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a1[i], a2[i]} !== {exp_r[i], exp_r[i]}) begin
        errors++;
        $display("FAIL b2b_resp_%0d: got r1=%h r2=%h, exp %h", i, a1[i], a2[i], exp_r[i]);
      end
    end
    checks++;
    if (tail1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail: got vld1=%b, exp 0", tail1);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] f1a, f1b, f2a, f2b;
    logic [33:0] r1, r2;
    logic e2, l1;
    @(negedge clk);
    instr_addr = 32'h4;
    req = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h4; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    f1a = idat1;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    f1b = idat1; f2a = idat2;
    @(posedge clk); #1;
    f2b = idat2;
    checks++;
    if ({f1a, f2a} !== {32'hBEEF_AB1F, 32'hBEEF_AB1F}) begin
      errors++;
      $display("FAIL fetch_read_first: got %h/%h, exp beefab1f", f1a, f2a);
    end
    checks++;
    if ({f1b, f2b} !== {32'h1234_5678, 32'h1234_5678}) begin
      errors++;
      $display("FAIL fetch_new: got %h/%h, exp 12345678", f1b, f2b);
    end
    access(1'b1, SZ_WORD, 32'h40, 32'hA5A5_A5A5, r1, r2, e2, l1);
    access(1'b0, SZ_WORD, 32'h0, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'hA5A5_A5A5, 2'b10, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL alias_wrap: got r1=%h r2=%h, exp data a5a5a5a5", r1, r2);
    end
    @(negedge clk);
    instr_addr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({idat1, idat2} !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL fetch_alias: got %h/%h, exp a5a5a5a5", idat1, idat2);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [33:0] r1, r2;
    logic e2, l1;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = SZ_WORD; addr = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({vld2, rdy1, rdy2, rdat2, idat1, idat2} !== {3'b000, 32'h0, INSTR_NOP, INSTR_NOP}) begin
      errors++;
      $display("FAIL midreset_drop: got vld2=%b rdy=%b%b rdat2=%h idat=%h/%h, exp no pulse, not ready, NOP",
               vld2, rdy1, rdy2, rdat2, idat1, idat2);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ready("midreset", n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL midreset_ready_delay: got %0d cycles, exp 16", n);
    end
    access(1'b0, SZ_WORD, 32'h4, 32'h0, r1, r2, e2, l1);
    checks++;
    if ({r1, r2} !== {2'b10, 32'h0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL midreset_cleared: got r1=%h r2=%h, exp data 00000000", r1, r2);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_misalign();
    test_back_to_back();
    test_fetch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
